// File: rtl/stm_transition_sched.sv
// stm_transition_sched: buffers host-issued STM segment-transition requests
// and hands them to the swapchain one at a time, holding back the next request
// until the previous one has switched segments and, for finite loops, stopped.
module stm_transition_sched #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  PUSH_VALID,
    output logic                  PUSH_READY,
    input  logic                  PUSH_SEGMENT,
    input  logic [7:0]            PUSH_MODE,
    input  logic [63:0]           PUSH_VALUE,
    input  logic [31:0]           PUSH_REP,
    input  logic                  FLUSH,
    input  logic                  SEGMENT,
    input  logic                  STOP,
    output logic                  UPDATE_SETTINGS,
    output logic                  REQ_RD_SEGMENT,
    output logic [7:0]            TRANSITION_MODE,
    output logic [63:0]           TRANSITION_VALUE,
    output logic [1:0][31:0]      REP,
    output logic                  BUSY,
    output logic [DEPTH_LOG2:0]   LEVEL
);

    localparam int                    DEPTH        = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   DEPTH_CNT    = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE      = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE      = DEPTH_LOG2'(1);
    localparam logic [31:0]           REP_INFINITE = 32'hFFFF_FFFF;

    typedef struct packed {
        logic        seg;
        logic [7:0]  mode;
        logic [63:0] value;
        logic [31:0] rep;
    } req_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_SWITCH,
        S_WAIT_STOP
    } state_t;

    req_t                  mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;

    state_t                state_q, state_d;
    logic                  stop_armed_q, stop_armed_d;
    logic                  strobe_q, strobe_d;

    logic                  seg_q, seg_d;
    logic [7:0]            mode_q, mode_d;
    logic [63:0]           value_q, value_d;
    logic [1:0][31:0]      rep_q, rep_d;

    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    req_t                  head;
    req_t                  push_req;

    assign full     = (count_q == DEPTH_CNT);
    assign empty    = (count_q == '0);
    assign head     = mem_q[rd_ptr_q];
    assign push_req = '{seg: PUSH_SEGMENT, mode: PUSH_MODE, value: PUSH_VALUE, rep: PUSH_REP};

    // FLUSH and RST both block acceptance so nothing lands in a queue being dropped.
    assign PUSH_READY = ~full & ~FLUSH & ~RST;
    assign push       = PUSH_VALID & PUSH_READY;

    // Request storage; contents are only meaningful between the pointers.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_req;
        end
    end

    // FIFO pointer and occupancy next-state; flush wins over push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (FLUSH) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Scheduler next-state: pop/issue, classify, then wait for switch and loop stop.
    always_comb begin
        state_d      = state_q;
        stop_armed_d = stop_armed_q;
        strobe_d     = 1'b0;
        pop          = 1'b0;
        seg_d        = seg_q;
        mode_d       = mode_q;
        value_d      = value_q;
        rep_d        = rep_q;
        case (state_q)
            S_IDLE: begin
                if (!FLUSH && !empty) begin
                    pop             = 1'b1;
                    seg_d           = head.seg;
                    mode_d          = head.mode;
                    value_d         = head.value;
                    rep_d[head.seg] = head.rep;
                    strobe_d        = 1'b1;
                    state_d         = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Infinite repeats and same-segment targets take effect at once.
                if (FLUSH || rep_q[seg_q] == REP_INFINITE || seg_q == SEGMENT) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_SWITCH;
                end
            end
            S_WAIT_SWITCH: begin
                if (FLUSH) begin
                    // Retarget the segment already playing so the pending switch never fires.
                    strobe_d = 1'b1;
                    seg_d    = SEGMENT;
                    state_d  = S_IDLE;
                end else if (SEGMENT == seg_q) begin
                    stop_armed_d = 1'b0;
                    state_d      = S_WAIT_STOP;
                end
            end
            S_WAIT_STOP: begin
                // The first cycle ignores STOP: it may still be the previous loop's flag.
                if (FLUSH || (stop_armed_q && STOP)) begin
                    state_d = S_IDLE;
                end else begin
                    stop_armed_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state: FSM, strobe and FIFO bookkeeping.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            stop_armed_q <= 1'b0;
            strobe_q     <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            stop_armed_q <= stop_armed_d;
            strobe_q     <= strobe_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Issued settings toward the swapchain; held stable between issues.
    always_ff @(posedge CLK) begin
        if (RST) begin
            seg_q   <= 1'b0;
            mode_q  <= '0;
            value_q <= '0;
            rep_q   <= {REP_INFINITE, REP_INFINITE};
        end else begin
            seg_q   <= seg_d;
            mode_q  <= mode_d;
            value_q <= value_d;
            rep_q   <= rep_d;
        end
    end

    // The strobe is masked by RST so a reset mid-issue drops it in the same cycle.
    assign UPDATE_SETTINGS  = strobe_q & ~RST;
    assign REQ_RD_SEGMENT   = seg_q;
    assign TRANSITION_MODE  = mode_q;
    assign TRANSITION_VALUE = value_q;
    assign REP              = rep_q;
    assign BUSY             = (state_q != S_IDLE) | ~empty;
    assign LEVEL            = count_q;

endmodule

// File: tb/tb_stm_transition_sched.sv
// Bench for stm_transition_sched: a queue-based reference model checked every
// cycle, plus directed scenarios with hand-derived expectations.
module tb_stm_transition_sched;

    localparam int          DEPTH_LOG2    = 2;
    localparam int          DEPTH         = 4;
    localparam logic [7:0]  MODE_SYNC_IDX = 8'h00;
    localparam logic [7:0]  MODE_SYS_TIME = 8'h01;
    localparam logic [7:0]  MODE_GPIO     = 8'h02;
    localparam logic [31:0] INF           = 32'hFFFF_FFFF;

    logic                CLK;
    logic                RST;
    logic                PUSH_VALID;
    logic                PUSH_READY;
    logic                PUSH_SEGMENT;
    logic [7:0]          PUSH_MODE;
    logic [63:0]         PUSH_VALUE;
    logic [31:0]         PUSH_REP;
    logic                FLUSH;
    logic                SEGMENT;
    logic                STOP;
    logic                UPDATE_SETTINGS;
    logic                REQ_RD_SEGMENT;
    logic [7:0]          TRANSITION_MODE;
    logic [63:0]         TRANSITION_VALUE;
    logic [1:0][31:0]    REP;
    logic                BUSY;
    logic [DEPTH_LOG2:0] LEVEL;

    int n_checks = 0;
    int n_err    = 0;

    stm_transition_sched #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .CLK              (CLK),
        .RST              (RST),
        .PUSH_VALID       (PUSH_VALID),
        .PUSH_READY       (PUSH_READY),
        .PUSH_SEGMENT     (PUSH_SEGMENT),
        .PUSH_MODE        (PUSH_MODE),
        .PUSH_VALUE       (PUSH_VALUE),
        .PUSH_REP         (PUSH_REP),
        .FLUSH            (FLUSH),
        .SEGMENT          (SEGMENT),
        .STOP             (STOP),
        .UPDATE_SETTINGS  (UPDATE_SETTINGS),
        .REQ_RD_SEGMENT   (REQ_RD_SEGMENT),
        .TRANSITION_MODE  (TRANSITION_MODE),
        .TRANSITION_VALUE (TRANSITION_VALUE),
        .REP              (REP),
        .BUSY             (BUSY),
        .LEVEL            (LEVEL)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic        seg;
        logic [7:0]  mode;
        logic [63:0] value;
        logic [31:0] rep;
    } mreq_t;

    mreq_t       mq[$];
    int          waiting_on = 0;   // 0 nothing, 1 strobe cycle, 2 segment switch, 3 loop stop
    int          stop_age   = 0;
    bit          armed      = 0;
    logic        m_strobe   = 1'b0;
    logic        m_req      = 1'b0;
    logic [7:0]  m_mode     = '0;
    logic [63:0] m_value    = '0;
    logic [31:0] m_rep [2]  = '{INF, INF};

    always @(posedge CLK) begin : model
        mreq_t h;
        mreq_t n;
        bit    accept;
        if (RST) begin
            mq.delete();
            waiting_on = 0;
            stop_age   = 0;
            m_strobe   = 1'b0;
            m_req      = 1'b0;
            m_mode     = '0;
            m_value    = '0;
            m_rep[0]   = INF;
            m_rep[1]   = INF;
            armed      = 1;
        end else begin
            accept  = PUSH_VALID && !FLUSH && (mq.size() < DEPTH);
            n.seg   = PUSH_SEGMENT;
            n.mode  = PUSH_MODE;
            n.value = PUSH_VALUE;
            n.rep   = PUSH_REP;
            m_strobe = 1'b0;
            if (FLUSH) begin
                if (waiting_on == 2) begin
                    m_strobe = 1'b1;
                    m_req    = SEGMENT;
                end
                mq.delete();
                waiting_on = 0;
            end else if (waiting_on == 0) begin
                if (mq.size() > 0) begin
                    h          = mq.pop_front();
                    m_req      = h.seg;
                    m_mode     = h.mode;
                    m_value    = h.value;
                    m_rep[h.seg ? 1 : 0] = h.rep;
                    m_strobe   = 1'b1;
                    waiting_on = 1;
                end
            end else if (waiting_on == 1) begin
                if (h.rep == INF || m_req == SEGMENT) waiting_on = 0;
                else waiting_on = 2;
            end else if (waiting_on == 2) begin
                if (SEGMENT == m_req) begin
                    waiting_on = 3;
                    stop_age   = 0;
                end
            end else begin
                if (stop_age > 0 && STOP) waiting_on = 0;
                else stop_age++;
            end
            if (accept) mq.push_back(n);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(posedge CLK) begin
        #2;
        if (armed) begin
            chk("update_settings", 64'(UPDATE_SETTINGS), 64'(m_strobe && !RST));
            chk("req_rd_segment", 64'(REQ_RD_SEGMENT), 64'(m_req));
            chk("transition_mode", 64'(TRANSITION_MODE), 64'(m_mode));
            chk("transition_value", TRANSITION_VALUE, m_value);
            chk("rep0", 64'(REP[0]), 64'(m_rep[0]));
            chk("rep1", 64'(REP[1]), 64'(m_rep[1]));
            chk("level", 64'(LEVEL), 64'(mq.size()));
            chk("push_ready", 64'(PUSH_READY), 64'(!RST && !FLUSH && (mq.size() < DEPTH)));
            chk("busy", 64'(BUSY), 64'(waiting_on != 0 || mq.size() != 0));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic push(input logic seg, input logic [7:0] mode, input logic [63:0] value,
                        input logic [31:0] rep);
        bit done;
        done         = 0;
        PUSH_VALID   = 1'b1;
        PUSH_SEGMENT = seg;
        PUSH_MODE    = mode;
        PUSH_VALUE   = value;
        PUSH_REP     = rep;
        for (int i = 0; i < 50 && !done; i++) begin
            #1;
            done = PUSH_READY;
            @(negedge CLK);
        end
        PUSH_VALID = 1'b0;
        chk("push_accepted", 64'(done), 64'(1));
    endtask

    task automatic wait_idle(input int limit);
        bit idle;
        idle = 0;
        for (int i = 0; i < limit && !idle; i++) begin
            tick();
            idle = !BUSY;
        end
        chk("idle_reached", 64'(idle), 64'(1));
    endtask

    initial begin
        bit d5_done;
        RST = 1'b1; PUSH_VALID = 1'b0; PUSH_SEGMENT = 1'b0; PUSH_MODE = '0;
        PUSH_VALUE = '0; PUSH_REP = '0; FLUSH = 1'b0; SEGMENT = 1'b0; STOP = 1'b0;
        repeat (3) tick();
        chk("rst_ready", 64'(PUSH_READY), 64'(0));
        chk("rst_rep0", 64'(REP[0]), 64'(INF));
        chk("rst_rep1", 64'(REP[1]), 64'(INF));
        chk("rst_level", 64'(LEVEL), 64'(0));
        chk("rst_upd", 64'(UPDATE_SETTINGS), 64'(0));
        RST = 1'b0;

        // Infinite-repeat request: strobe two edges after the push edge, then idle.
        push(1'b1, MODE_SYNC_IDX, 64'd0, INF);
        chk("t1_level", 64'(LEVEL), 64'(1));
        chk("t1_no_strobe_yet", 64'(UPDATE_SETTINGS), 64'(0));
        tick();
        chk("t1_strobe", 64'(UPDATE_SETTINGS), 64'(1));
        chk("t1_req", 64'(REQ_RD_SEGMENT), 64'(1));
        chk("t1_rep1", 64'(REP[1]), 64'(INF));
        tick();
        chk("t1_strobe_single", 64'(UPDATE_SETTINGS), 64'(0));
        chk("t1_idle", 64'(BUSY), 64'(0));

        // Finite loop on seg1 followed by seg0: second issue gated by switch and stop.
        push(1'b1, MODE_SYS_TIME, 64'd1000, 32'd3);
        push(1'b0, MODE_SYNC_IDX, 64'd0, INF);
        chk("t2_strobe", 64'(UPDATE_SETTINGS), 64'(1));
        chk("t2_mode", 64'(TRANSITION_MODE), 64'(MODE_SYS_TIME));
        chk("t2_value", TRANSITION_VALUE, 64'd1000);
        chk("t2_rep1", 64'(REP[1]), 64'(3));
        chk("t2_level_push_pop", 64'(LEVEL), 64'(1));
        repeat (5) tick();
        chk("t2_held", 64'(UPDATE_SETTINGS), 64'(0));
        chk("t2_busy", 64'(BUSY), 64'(1));
        SEGMENT = 1'b1;
        repeat (2) tick();
        chk("t2_wait_stop", 64'(UPDATE_SETTINGS), 64'(0));
        STOP = 1'b1;
        tick();
        STOP = 1'b0;
        chk("t2_not_yet", 64'(UPDATE_SETTINGS), 64'(0));
        tick();
        chk("t2_second_strobe", 64'(UPDATE_SETTINGS), 64'(1));
        chk("t2_second_req", 64'(REQ_RD_SEGMENT), 64'(0));
        chk("t2_rep1_kept", 64'(REP[1]), 64'(3));
        tick();
        chk("t2_idle", 64'(BUSY), 64'(0));

        // Fill the FIFO while a request waits for its switch.
        push(1'b0, MODE_GPIO, 64'd5, 32'd2);
        tick();
        chk("t3_strobe", 64'(UPDATE_SETTINGS), 64'(1));
        chk("t3_rep0", 64'(REP[0]), 64'(2));
        tick();
        for (int i = 1; i <= 4; i++) push(1'b1, MODE_SYNC_IDX, 64'(i), INF);
        chk("t3_full_level", 64'(LEVEL), 64'(4));
        chk("t3_full_ready", 64'(PUSH_READY), 64'(0));
        PUSH_VALID = 1'b1; PUSH_SEGMENT = 1'b1; PUSH_MODE = MODE_SYNC_IDX;
        PUSH_VALUE = 64'd5; PUSH_REP = INF;
        repeat (2) tick();
        #1;
        chk("t3_fifth_held", 64'(PUSH_READY), 64'(0));
        chk("t3_level_held", 64'(LEVEL), 64'(4));
        SEGMENT = 1'b0;
        STOP    = 1'b1;
        repeat (3) tick();
        chk("t3_stale_stop", 64'(UPDATE_SETTINGS), 64'(0));
        tick();
        STOP = 1'b0;
        chk("t3_pop_strobe", 64'(UPDATE_SETTINGS), 64'(1));
        chk("t3_pop_value", TRANSITION_VALUE, 64'd1);
        d5_done = 0;
        for (int i = 0; i < 10 && !d5_done; i++) begin
            #1;
            d5_done = PUSH_READY;
            tick();
        end
        PUSH_VALID = 1'b0;
        chk("t3_fifth_accepted", 64'(d5_done), 64'(1));
        chk("t3_level_refill", 64'(LEVEL), 64'(4));
        wait_idle(60);

        // FLUSH while waiting for a switch: one cancel strobe to the live segment.
        push(1'b1, MODE_SYS_TIME, 64'd77, 32'd4);
        tick();
        chk("t4_strobe", 64'(UPDATE_SETTINGS), 64'(1));
        tick();
        push(1'b1, MODE_GPIO, 64'd88, 32'd6);
        chk("t4_level", 64'(LEVEL), 64'(1));
        FLUSH = 1'b1;
        tick();
        chk("t4_cancel_strobe", 64'(UPDATE_SETTINGS), 64'(1));
        chk("t4_cancel_req", 64'(REQ_RD_SEGMENT), 64'(0));
        chk("t4_mode_kept", 64'(TRANSITION_MODE), 64'(MODE_SYS_TIME));
        chk("t4_value_kept", TRANSITION_VALUE, 64'd77);
        chk("t4_rep1_kept", 64'(REP[1]), 64'(4));
        chk("t4_level_zero", 64'(LEVEL), 64'(0));
        FLUSH = 1'b0;
        repeat (3) tick();
        chk("t4_no_more", 64'(UPDATE_SETTINGS), 64'(0));
        chk("t4_idle", 64'(BUSY), 64'(0));

        // Reset during the strobe cycle.
        push(1'b1, MODE_SYS_TIME, 64'd9, 32'd5);
        push(1'b0, MODE_GPIO, 64'd1, 32'd7);
        chk("t5_strobe", 64'(UPDATE_SETTINGS), 64'(1));
        chk("t5_level", 64'(LEVEL), 64'(1));
        RST = 1'b1;
        PUSH_VALID = 1'b1;
        #1;
        chk("t5_strobe_dropped", 64'(UPDATE_SETTINGS), 64'(0));
        chk("t5_ready_low", 64'(PUSH_READY), 64'(0));
        tick();
        chk("t5_rep0", 64'(REP[0]), 64'(INF));
        chk("t5_rep1", 64'(REP[1]), 64'(INF));
        chk("t5_level", 64'(LEVEL), 64'(0));
        tick();
        chk("t5_no_push_in_rst", 64'(LEVEL), 64'(0));
        RST = 1'b0;
        PUSH_VALID = 1'b0;
        tick();
        chk("t5_idle", 64'(BUSY), 64'(0));

        // Same-segment finite request completes without waiting for a switch.
        push(1'b0, MODE_GPIO, 64'd3, 32'd2);
        tick();
        chk("t6_strobe", 64'(UPDATE_SETTINGS), 64'(1));
        chk("t6_rep0", 64'(REP[0]), 64'(2));
        tick();
        chk("t6_single", 64'(UPDATE_SETTINGS), 64'(0));
        chk("t6_idle", 64'(BUSY), 64'(0));
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
        $fatal(1);
    end

endmodule
